// File: rtl/bus_int_ctl.sv
// bus_int_ctl - multi-channel Q-bus interrupt request controller.
//
// Collects NCH enabled request sources into a pending register. A
// fixed-priority arbiter (lowest index wins) picks one channel, raises the bus
// interrupt, and on acknowledge presents that channel's vector
// (VBASE + 4*ch, truncated to VW bits) and clears the channel's pending bit.
//
// Optional feature: define BUS_INT_EDGE_EN to switch the pending-set rule
// from level-sensitive (ena & req) to rising-edge detection of req while
// enabled. Without the macro the block runs in level mode.
//
// Ports:
//   clk_i  - system clock, rising edge
//   rst_i  - asynchronous active-high reset
//   ena_i  - per-channel interrupt enable [NCH]
//   req_i  - per-channel interrupt request [NCH]
//   ack_i  - bus interrupt acknowledge (held high for the whole phase)
//   irq_o  - registered bus interrupt request
//   vld_o  - registered vector-valid (acknowledge phase)
//   vec_o  - registered vector of serviced channel, 0 when vld_o=0
//   ch_o   - registered index of armed/serviced channel, 0 in IDLE

module bus_int_ctl #(
    parameter int unsigned   NCH   = 4,
    parameter int unsigned   VW    = 9,
    parameter logic [VW-1:0] VBASE = 9'o120
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [NCH-1:0] ena_i,
    input  logic [NCH-1:0] req_i,
    input  logic           ack_i,
    output logic           irq_o,
    output logic           vld_o,
    output logic [VW-1:0]  vec_o,
    output logic [2:0]     ch_o
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        VEC
    } state_t;

    state_t         state;
    state_t         state_nx;

    logic [NCH-1:0] pend;
    logic [NCH-1:0] pend_nx;
    logic [NCH-1:0] set_req;

    logic [2:0]     win;
    logic           any_pend;
    logic           ena_sel;
    logic           svc;

    logic           irq_nx;
    logic           vld_nx;
    logic [VW-1:0]  vec_nx;
    logic [2:0]     ch_nx;

    function automatic logic [VW-1:0] vec_of(input logic [2:0] c);
        return VBASE + VW'({c, 2'b00});
    endfunction

    // ------------------------------------------------------------------
    // Pending-set condition
    // ------------------------------------------------------------------
`ifdef BUS_INT_EDGE_EN
    logic [NCH-1:0] req_prev;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_prev <= '0;
        end else begin
            req_prev <= req_i;
        end
    end

    // Edges seen while disabled are dropped, not remembered.
    always_comb begin
        set_req = ena_i & req_i & ~req_prev;
    end
`else
    always_comb begin
        set_req = ena_i & req_i;
    end
`endif

    // ------------------------------------------------------------------
    // Arbiter and armed-channel enable select
    // ------------------------------------------------------------------
    always_comb begin
        logic found;
        found    = 1'b0;
        win      = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (pend[i] && !found) begin
                win   = 3'(i);
                found = 1'b1;
            end
        end
        any_pend = found;
    end

    always_comb begin
        ena_sel = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (ch_o == 3'(i)) begin
                ena_sel = ena_i[i];
            end
        end
    end

    // Service happens on the ARM -> VEC transition.
    always_comb begin
        svc = (state == ARM) && ena_sel && ack_i;
    end

    // ------------------------------------------------------------------
    // Pending register: set beats service clear in the same cycle
    // ------------------------------------------------------------------
    always_comb begin
        pend_nx = pend;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (set_req[i]) begin
                pend_nx[i] = 1'b1;
            end else if (!ena_i[i]) begin
                pend_nx[i] = 1'b0;
            end else if (svc && (ch_o == 3'(i))) begin
                pend_nx[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend <= '0;
        end else begin
            pend <= pend_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register (outputs registered alongside)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            irq_o <= 1'b0;
            vld_o <= 1'b0;
            vec_o <= '0;
            ch_o  <= '0;
        end else begin
            state <= state_nx;
            irq_o <= irq_nx;
            vld_o <= vld_nx;
            vec_o <= vec_nx;
            ch_o  <= ch_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (any_pend) begin
                    state_nx = ARM;
                end
            end
            ARM: begin
                if (!ena_sel) begin
                    state_nx = IDLE;
                end else if (ack_i) begin
                    state_nx = VEC;
                end
            end
            VEC: begin
                // Waiting for ack low here is what blocks a stale ack
                // from re-triggering on the following request.
                if (!ack_i) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode, computed from the next state so that the
    // registered outputs line up with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        irq_nx = 1'b0;
        vld_nx = 1'b0;
        vec_nx = '0;
        ch_nx  = '0;
        case (state_nx)
            ARM: begin
                irq_nx = 1'b1;
                ch_nx  = (state == IDLE) ? win : ch_o;
            end
            VEC: begin
                vld_nx = 1'b1;
                ch_nx  = ch_o;
                vec_nx = vec_of(ch_o);
            end
            default: begin
                irq_nx = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_int_ctl.sv
module tb_bus_int_ctl;

    localparam int NCH     = 4;
    localparam int VW      = 9;
    localparam int VBASE_I = 'o120;

    logic           clk = 1'b0;
    logic           rst;
    logic           ack;
    logic [NCH-1:0] ena;
    logic [NCH-1:0] req;
    logic           irq;
    logic           vld;
    logic [VW-1:0]  vec;
    logic [2:0]     ch;

    int total = 0;
    int bad   = 0;

    bus_int_ctl #(
        .NCH   (NCH),
        .VW    (VW),
        .VBASE (9'o120)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .ena_i (ena),
        .req_i (req),
        .ack_i (ack),
        .irq_o (irq),
        .vld_o (vld),
        .vec_o (vec),
        .ch_o  (ch)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: which channel is being offered (m_cur, -1 none),
    // whether the bus is currently taking its vector (m_deliv), and the
    // set of channels still owed an interrupt.
    // ------------------------------------------------------------------
    bit m_pend [NCH];
    bit m_prev [NCH];
    int m_cur   = -1;
    bit m_deliv = 1'b0;
    bit m_serve;
    bit m_set;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cur   = -1;
            m_deliv = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_pend[i] = 1'b0;
                m_prev[i] = 1'b0;
            end
        end else begin
            m_serve = 1'b0;
            if (m_deliv) begin
                if (!ack) begin
                    m_deliv = 1'b0;
                    m_cur   = -1;
                end
            end else if (m_cur >= 0) begin
                if (!ena[m_cur]) begin
                    m_cur = -1;
                end else if (ack) begin
                    m_deliv = 1'b1;
                    m_serve = 1'b1;
                end
            end else begin
                for (int i = NCH - 1; i >= 0; i--) begin
                    if (m_pend[i]) m_cur = i;
                end
            end
            for (int i = 0; i < NCH; i++) begin
`ifdef BUS_INT_EDGE_EN
                m_set = ena[i] && req[i] && !m_prev[i];
`else
                m_set = ena[i] && req[i];
`endif
                if (m_set)                     m_pend[i] = 1'b1;
                else if (!ena[i])              m_pend[i] = 1'b0;
                else if (m_serve && m_cur == i) m_pend[i] = 1'b0;
                m_prev[i] = req[i];
            end
        end
    end

    function automatic int exp_irq();
        return (m_cur >= 0 && !m_deliv) ? 1 : 0;
    endfunction
    function automatic int exp_vec();
        return m_deliv ? ((VBASE_I + 4 * m_cur) % (1 << VW)) : 0;
    endfunction
    function automatic int exp_ch();
        return (m_cur < 0) ? 0 : m_cur;
    endfunction

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at t=%0t", name, got, want, $time);
        end
    endtask

    // Model comparison on every falling edge.
    always @(negedge clk) begin
        check("m_irq", int'(irq), exp_irq());
        check("m_vld", int'(vld), int'(m_deliv));
        check("m_vec", int'(vec), exp_vec());
        check("m_ch",  int'(ch),  exp_ch());
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        req = '0;
        ack = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (irq) begin
                ack = 1'b1;
                tick();
                ack = 1'b0;
            end
        end
        check("drain_irq", int'(irq), 0);
        check("drain_vld", int'(vld), 0);
    endtask

    initial begin
        rst = 1'b1;
        ack = 1'b0;
        ena = '0;
        req = '0;
        tick();
        tick();
        check("rst_irq", int'(irq), 0);
        check("rst_vld", int'(vld), 0);
        check("rst_vec", int'(vec), 0);
        check("rst_ch",  int'(ch),  0);
        rst = 1'b0;

        // Two requests: ch1 wins, then ch3.
        ena = 4'b1111;
        req = 4'b1010;
        tick();
        check("s2_lat_irq", int'(irq), 0);
        tick();
        check("s2_irq", int'(irq), 1);
        check("s2_ch",  int'(ch),  1);
        req = '0;
        ack = 1'b1;
        tick();
        check("s2_vld1", int'(vld), 1);
        check("s2_vec1", int'(vec), 'o124);
        check("s2_irq_off", int'(irq), 0);
        ack = 1'b0;
        tick();
        check("s2_vld_off", int'(vld), 0);
        check("s2_vec_off", int'(vec), 0);
        check("s2_ch_idle", int'(ch), 0);
        tick();
        check("s2_irq3", int'(irq), 1);
        check("s2_ch3",  int'(ch),  3);
        ack = 1'b1;
        tick();
        check("s2_vec3", int'(vec), 'o134);
        ack = 1'b0;
        tick();
        tick();
        check("s2_quiet", int'(irq), 0);

        // Cancel on ch2 by dropping its enable.
        req = 4'b0100;
        tick();
        tick();
        check("s3_irq", int'(irq), 1);
        check("s3_ch",  int'(ch),  2);
        req = '0;
        ena = 4'b1011;
        tick();
        check("s3_cancel_irq", int'(irq), 0);
        check("s3_cancel_vld", int'(vld), 0);
        ena = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s3_no_irq", int'(irq), 0);
            check("s3_no_vld", int'(vld), 0);
        end

        // No preemption: ch3 armed, ch0 arrives.
        req = 4'b1000;
        tick();
        tick();
        check("s4_ch3", int'(ch), 3);
        req = 4'b1001;
        tick();
        check("s4_still3", int'(ch), 3);
        check("s4_irq", int'(irq), 1);
        req = '0;
        ack = 1'b1;
        tick();
        check("s4_vec3", int'(vec), 'o134);
        ack = 1'b0;
        tick();
        tick();
        check("s4_ch0", int'(ch), 0);
        check("s4_irq0", int'(irq), 1);
        ack = 1'b1;
        tick();
        check("s4_vec0", int'(vec), 'o120);
        ack = 1'b0;
        tick();
        tick();
        check("s4_quiet", int'(irq), 0);

        // Held request across service.
        req = 4'b0001;
        tick();
        tick();
        check("s5_irq", int'(irq), 1);
        ack = 1'b1;
        tick();
        check("s5_vld", int'(vld), 1);
        ack = 1'b0;
        tick();
        check("s5_gap", int'(irq), 0);
        tick();
`ifdef BUS_INT_EDGE_EN
        check("s5_no_reirq", int'(irq), 0);
        tick();
        check("s5_no_reirq2", int'(irq), 0);
        req = '0;
        tick();
        req = 4'b0001;
        tick();
        check("s5_edge_lat", int'(irq), 0);
        tick();
        check("s5_edge_irq", int'(irq), 1);
`else
        check("s5_reirq", int'(irq), 1);
        check("s5_reirq_ch", int'(ch), 0);
`endif
        drain();

        // Stale ack in IDLE and a long ack in VEC.
        ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s6_idle_irq", int'(irq), 0);
            check("s6_idle_vld", int'(vld), 0);
        end
        ack = 1'b0;
        req = 4'b0010;
        tick();
        tick();
        check("s6_ch1", int'(ch), 1);
        req = '0;
        ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s6_hold_vld", int'(vld), 1);
            check("s6_hold_vec", int'(vec), 'o124);
            check("s6_hold_irq", int'(irq), 0);
        end
        ack = 1'b0;
        tick();
        check("s6_vld_fall", int'(vld), 0);
        tick();
        check("s6_quiet", int'(irq), 0);

        // Reset in VEC with ack high.
        req = 4'b0001;
        tick();
        tick();
        ack = 1'b1;
        req = '0;
        tick();
        check("s1_vec_vld", int'(vld), 1);
        rst = 1'b1;
        tick();
        check("s1_rst_irq", int'(irq), 0);
        check("s1_rst_vld", int'(vld), 0);
        check("s1_rst_vec", int'(vec), 0);
        check("s1_rst_ch",  int'(ch),  0);
        rst = 1'b0;
        ack = 1'b0;
        req = 4'b0001;
        tick();
        check("s1_lat", int'(irq), 0);
        tick();
        check("s1_irq", int'(irq), 1);
        drain();

        // Randomised traffic checked by the model process.
        for (int i = 0; i < 3000; i++) begin
            ena = 4'($urandom) | 4'($urandom);
            if ($urandom_range(0, 3) == 0) ena = 4'b1111;
            req = 4'($urandom) & 4'($urandom);
            ack = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
